// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipe: load-use stalls, taken-branch flushes,
// and a full-pipe freeze while a data-memory access is outstanding.
module pipeline_hazard_ctrl #(
   parameter int unsigned MAX_WAIT = 16,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             IDEX_MemRead,
   input  logic [4:0]       IDEX_Rt,
   input  logic [4:0]       IFID_Rs,
   input  logic [4:0]       IFID_Rt,
   input  logic             IFID_UsesRt,
   input  logic             EXMEM_Branch,
   input  logic             EXMEM_Zero,
   input  logic             EXMEM_MemReq,
   input  logic             MemReady,
   output logic             PCWrite,
   output logic             PCSrc,
   output logic             IFIDWrite,
   output logic             IDEXWrite,
   output logic             EXMEMWrite,
   output logic             MEMWBWrite,
   output logic             IDEXBubble,
   output logic             FlushIFID,
   output logic             FlushIDEX,
   output logic [CNT_W-1:0] StallCount,
   output logic             MemTimeout
);

   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              mem_stall;
   logic              taken;
   logic              load_use;

   assign mem_stall = EXMEM_MemReq & ~MemReady;
   assign taken     = EXMEM_Branch & EXMEM_Zero;
   assign load_use  = IDEX_MemRead & (IDEX_Rt != 5'd0) &
                      ((IDEX_Rt == IFID_Rs) | (IFID_UsesRt & (IDEX_Rt == IFID_Rt)));

   // State register
   always_ff @(posedge Clk) begin
      if (Rst) state <= RUN;
      else     state <= state_nxt;
   end

   // Next-state logic: stay frozen while the memory access is outstanding
   always_comb begin
      state_nxt = state;
      unique case (state)
         RUN:      if (mem_stall)  state_nxt = MEM_WAIT;
         MEM_WAIT: if (!mem_stall) state_nxt = RUN;
         default:  state_nxt = RUN;
      endcase
   end

   // Output decode; the MEM_WAIT exit cycle applies the same decode as RUN,
   // so both states share it and mem_stall alone selects the freeze.
   always_comb begin
      PCWrite    = 1'b1;
      PCSrc      = 1'b0;
      IFIDWrite  = 1'b1;
      IDEXWrite  = 1'b1;
      EXMEMWrite = 1'b1;
      MEMWBWrite = 1'b1;
      IDEXBubble = 1'b0;
      FlushIFID  = 1'b0;
      FlushIDEX  = 1'b0;
      if (!Rst) begin
         if (mem_stall) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMWrite = 1'b0;
            MEMWBWrite = 1'b0;
         end else if (taken) begin
            PCSrc     = 1'b1;
            FlushIFID = 1'b1;
            FlushIDEX = 1'b1;
         end else if (load_use) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
         end
      end
   end

   // Wait counter and sticky timeout; timeout never releases the freeze
   always_ff @(posedge Clk) begin
      if (Rst) begin
         wait_cnt   <= '0;
         MemTimeout <= 1'b0;
      end else begin
         unique case (state)
            RUN: wait_cnt <= mem_stall ? WAIT_W'(1) : '0;
            MEM_WAIT: begin
               if (mem_stall) begin
                  if (wait_cnt < WAIT_W'(MAX_WAIT)) wait_cnt <= wait_cnt + WAIT_W'(1);
                  if (wait_cnt == WAIT_W'(MAX_WAIT)) MemTimeout <= 1'b1;
               end else begin
                  wait_cnt <= '0;
               end
            end
            default: wait_cnt <= '0;
         endcase
      end
   end

   // Saturating count of cycles the PC was held
   always_ff @(posedge Clk) begin
      if (Rst)                              StallCount <= '0;
      else if (!PCWrite && StallCount != '1) StallCount <= StallCount + CNT_W'(1);
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table for single-cycle decode plus
// sequences for memory freeze, timeout, reset-in-wait and counter saturation.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned MAX_WAIT = 4;
   localparam int unsigned CNT_W    = 4;

   // {PCWrite,PCSrc,IFIDWrite,IDEXWrite,EXMEMWrite,MEMWBWrite,IDEXBubble,FlushIFID,FlushIDEX}
   localparam logic [8:0] E_DEF = 9'b1_0_1111_0_00;
   localparam logic [8:0] E_LU  = 9'b0_0_0111_1_00;
   localparam logic [8:0] E_BR  = 9'b1_1_1111_0_11;
   localparam logic [8:0] E_FRZ = 9'b0_0_0000_0_00;

   typedef struct {
      logic       rst;
      logic       mr;
      logic [4:0] irt;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       ur;
      logic       br;
      logic       z;
      logic       req;
      logic       rdy;
      logic [8:0] exp;
      logic       to;
   } vec_t;

   logic             Clk = 1'b0;
   logic             Rst;
   logic             IDEX_MemRead;
   logic [4:0]       IDEX_Rt;
   logic [4:0]       IFID_Rs;
   logic [4:0]       IFID_Rt;
   logic             IFID_UsesRt;
   logic             EXMEM_Branch;
   logic             EXMEM_Zero;
   logic             EXMEM_MemReq;
   logic             MemReady;
   logic             PCWrite, PCSrc, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite;
   logic             IDEXBubble, FlushIFID, FlushIDEX;
   logic [CNT_W-1:0] StallCount;
   logic             MemTimeout;

   int               checks = 0;
   int               errors = 0;
   logic [CNT_W-1:0] exp_cnt = '0;
   vec_t             sb_q[$];

   pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .Rst(Rst),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
      .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
      .EXMEM_Branch(EXMEM_Branch), .EXMEM_Zero(EXMEM_Zero),
      .EXMEM_MemReq(EXMEM_MemReq), .MemReady(MemReady),
      .PCWrite(PCWrite), .PCSrc(PCSrc), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
      .EXMEMWrite(EXMEMWrite), .MEMWBWrite(MEMWBWrite), .IDEXBubble(IDEXBubble),
      .FlushIFID(FlushIFID), .FlushIDEX(FlushIDEX),
      .StallCount(StallCount), .MemTimeout(MemTimeout)
   );

   always #5 Clk = ~Clk;

   function automatic vec_t mk(input logic rst, input logic mr, input logic [4:0] irt,
                               input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                               input logic br, input logic z, input logic req,
                               input logic rdy, input logic [8:0] e, input logic to);
      vec_t v;
      v.rst = rst; v.mr = mr; v.irt = irt; v.rs = rs; v.rt = rt; v.ur = ur;
      v.br = br; v.z = z; v.req = req; v.rdy = rdy; v.exp = e; v.to = to;
      return v;
   endfunction

   // One clock: drive, queue expectation, check decode at negedge, check state after edge
   task automatic cycle(input vec_t v, input string nm);
      vec_t       e;
      logic [8:0] got;
      Rst = v.rst; IDEX_MemRead = v.mr; IDEX_Rt = v.irt; IFID_Rs = v.rs; IFID_Rt = v.rt;
      IFID_UsesRt = v.ur; EXMEM_Branch = v.br; EXMEM_Zero = v.z;
      EXMEM_MemReq = v.req; MemReady = v.rdy;
      sb_q.push_back(v);
      @(negedge Clk);
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard empty", nm);
         return;
      end
      e = sb_q.pop_front();
      got = {PCWrite, PCSrc, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite,
             IDEXBubble, FlushIFID, FlushIDEX};
      if (got !== e.exp) begin
         errors++;
         $display("FAIL %s ctrl got %b want %b", nm, got, e.exp);
      end
      @(posedge Clk);
      #1;
      if (e.rst)                            exp_cnt = '0;
      else if (!e.exp[8] && exp_cnt != '1) exp_cnt = exp_cnt + CNT_W'(1);
      checks++;
      if (StallCount !== exp_cnt) begin
         errors++;
         $display("FAIL %s stall_count got %0d want %0d", nm, StallCount, exp_cnt);
      end
      checks++;
      if (MemTimeout !== e.to) begin
         errors++;
         $display("FAIL %s mem_timeout got %b want %b", nm, MemTimeout, e.to);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[10];
      vec_t rs_v, st_v, rd_v, lu_v, v;

      tbl[0] = mk(0, 1, 8, 8, 0, 0, 0, 0, 0, 0, E_LU,  0); // lw $t0 -> add rs=$t0
      tbl[1] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_DEF, 0); // $zero never hazards
      tbl[2] = mk(0, 1, 8, 8, 0, 0, 1, 1, 0, 0, E_BR,  0); // branch masks load-use
      tbl[3] = mk(0, 1, 9, 1, 9, 1, 0, 0, 0, 0, E_LU,  0); // rt match, rt used
      tbl[4] = mk(0, 1, 9, 1, 9, 0, 0, 0, 0, 0, E_DEF, 0); // rt match, rt unused
      tbl[5] = mk(0, 0, 8, 8, 8, 1, 0, 0, 0, 0, E_DEF, 0); // not a load
      tbl[6] = mk(0, 1, 8, 8, 0, 0, 1, 0, 0, 0, E_LU,  0); // branch not taken
      tbl[7] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, E_BR,  0); // taken alone
      tbl[8] = mk(0, 1, 31, 31, 0, 0, 0, 0, 1, 1, E_LU, 0); // memory ready, no freeze
      tbl[9] = mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, E_DEF, 0); // rt=0 with UsesRt

      rs_v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_DEF, 0);
      st_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 0);
      rd_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_DEF, 0);
      lu_v = mk(0, 1, 8, 8, 0, 0, 0, 0, 0, 0, E_LU,  0);

      cycle(rs_v, "reset");
      for (int i = 0; i < 10; i++) cycle(tbl[i], $sformatf("tbl%0d", i));

      // Freeze beats a concurrent taken branch and load-use; branch resolves on exit
      for (int i = 0; i < 3; i++)
         cycle(mk(0, 1, 8, 8, 0, 0, 1, 1, 1, 0, E_FRZ, 0), $sformatf("freeze%0d", i));
      cycle(mk(0, 1, 8, 8, 0, 0, 1, 1, 1, 1, E_BR, 0), "freeze_exit_br");
      cycle(lu_v, "after_exit_lu");

      // Timeout after WaitCnt reaches MAX_WAIT, sticky through ready, cleared by reset
      cycle(rs_v, "reset_to");
      for (int i = 0; i < 6; i++) begin
         v = st_v;
         v.to = (i >= 4);
         cycle(v, $sformatf("to_wait%0d", i));
      end
      v = rd_v; v.to = 1'b1; cycle(v, "to_ready");
      v = st_v; v.to = 1'b1; cycle(v, "to_sticky");
      v = rd_v; v.to = 1'b1; cycle(v, "to_ready2");
      cycle(rs_v, "to_clear");

      // Wait counter restarts on every exit
      for (int i = 0; i < 4; i++) cycle(st_v, $sformatf("wa%0d", i));
      cycle(rd_v, "wa_exit");
      for (int i = 0; i < 4; i++) cycle(st_v, $sformatf("wb%0d", i));
      cycle(rd_v, "wb_exit");

      // Reset while waiting abandons the wait and the count
      cycle(st_v, "rw0");
      cycle(st_v, "rw1");
      cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_DEF, 0), "rw_reset");
      cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_DEF, 0), "rw_run");
      for (int i = 0; i < 4; i++) cycle(st_v, $sformatf("rw_wait%0d", i));
      cycle(rd_v, "rw_exit");

      // StallCount saturates without wrapping
      for (int i = 0; i < 20; i++) cycle(lu_v, $sformatf("sat%0d", i));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
